// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register for the 5-stage core. It carries an
// opaque payload and a valid bit between a producer stage (STAGE) and its
// consumer stage (STAGE+1). It also provides:
//   - an exception flush
//   - bubble tagging
//   - a hold-age counter
//
// Per-cycle action, highest priority first:
//   1. rst      load the nop payload, clear valid, bubble and age
//   2. flush    load the nop payload, clear valid, bubble and age
//   3. BUBBLE   up & !down: load the nop payload and tag it as a bubble
//   4. HOLD     up &  down: keep the content, age increments and saturates
//   5. ADVANCE  !up: load in_data and in_valid
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, four saturating event counters are built: stall, bubble,
//   flush and valid. When undefined, perf_clr is ignored and the perf_*
//   outputs are tied to 0.
//
// Ports:
//   clk, rst       clock (rising edge) and synchronous active-high reset
//   stall          stall vector; stall[k]=1 freezes stage k
//   flush          flush of this boundary (overrides any stall combination)
//   in_data        payload from the producer stage
//   in_valid       the producer holds a real instruction
//   out_data       registered payload to the consumer stage
//   out_valid      out_data is a real instruction
//   out_bubble     the current content is an inserted bubble
//   out_hold_age   consecutive cycles the current content has been held
//   perf_clr       clears all perf counters
//   perf_stall     cycles spent in HOLD
//   perf_bubble    bubbles inserted
//   perf_flush     flushes taken
//   perf_valid     valid instructions accepted
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W    = 128,
    parameter int                STAGE     = 2,
    parameter int                STALL_W   = 6,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                AGE_W     = 8,
    parameter int                CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_bubble,
    output logic [AGE_W-1:0]   out_hold_age,
    input  logic               perf_clr,
    output logic [CNT_W-1:0]   perf_stall,
    output logic [CNT_W-1:0]   perf_bubble,
    output logic [CNT_W-1:0]   perf_flush,
    output logic [CNT_W-1:0]   perf_valid
);

    logic up;
    logic down;

    assign up = stall[STAGE];

    // The last stage has no consumer stall bit, so down is forced to 0.
    generate
        if (STAGE < STALL_W - 1) begin : g_down
            assign down = stall[STAGE+1];
        end else begin : g_no_down
            assign down = 1'b0;
        end
    endgenerate

    // Stall bits belonging to other stages are intentionally not used here.
    logic unused_stall;
    assign unused_stall = ^stall;

    logic do_bubble;
    logic do_hold;
    logic do_advance;

    // !up & down is an inconsistent stall request and is treated as ADVANCE.
    assign do_bubble  = up & ~down;
    assign do_hold    = up & down;
    assign do_advance = ~up;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_data     <= NOP_VALUE;
            out_valid    <= 1'b0;
            out_bubble   <= 1'b0;
            out_hold_age <= '0;
        end else if (do_bubble) begin
            out_data     <= NOP_VALUE;
            out_valid    <= 1'b0;
            out_bubble   <= 1'b1;
            out_hold_age <= '0;
        end else if (do_hold) begin
            // Content (including a held bubble tag) is kept; only the age moves.
            if (out_hold_age != {AGE_W{1'b1}}) begin
                out_hold_age <= out_hold_age + AGE_W'(1);
            end
        end else begin
            // On ADVANCE the payload is loaded as-is, even when in_valid is 0.
            out_data     <= in_data;
            out_valid    <= in_valid;
            out_bubble   <= 1'b0;
            out_hold_age <= '0;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // An event counts only if it is the action actually taken, so rst and
    // flush mask the stall-derived events.
    logic ev_hold;
    logic ev_bubble;
    logic ev_flush;
    logic ev_valid;

    assign ev_flush  = ~rst & flush;
    assign ev_bubble = ~rst & ~flush & do_bubble;
    assign ev_hold   = ~rst & ~flush & do_hold;
    assign ev_valid  = ~rst & ~flush & do_advance & in_valid;

    // perf_clr wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            perf_stall  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
            perf_valid  <= '0;
        end else begin
            if (ev_hold && perf_stall != {CNT_W{1'b1}}) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
            if (ev_bubble && perf_bubble != {CNT_W{1'b1}}) begin
                perf_bubble <= perf_bubble + CNT_W'(1);
            end
            if (ev_flush && perf_flush != {CNT_W{1'b1}}) begin
                perf_flush <= perf_flush + CNT_W'(1);
            end
            if (ev_valid && perf_valid != {CNT_W{1'b1}}) begin
                perf_valid <= perf_valid + CNT_W'(1);
            end
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;

    assign perf_stall  = '0;
    assign perf_bubble = '0;
    assign perf_flush  = '0;
    assign perf_valid  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed testbench for pipe_stage_reg. Two instances share every input:
//   dut    AGE_W=8, the main instance
//   dut2   AGE_W=2, used to observe hold-age saturation
// Both instances use DATA_W=16, STAGE=2 and a non-zero NOP_VALUE. The
// non-zero NOP_VALUE makes a load of the nop payload distinguishable from
// a load of zero.
//
// Perf-counter expectations are the hand-derived counts when
// PIPE_STAGE_PERF_EN is defined, and 0 otherwise.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DATA_W = 16;
    localparam int          CNT_W  = 32;
    localparam logic [15:0] NOP    = 16'h0F0F;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              perf_clr;

    logic [DATA_W-1:0] out_data,  out_data2;
    logic              out_valid, out_valid2;
    logic              out_bubble, out_bubble2;
    logic [7:0]        out_hold_age;
    logic [1:0]        out_hold_age2;
    logic [CNT_W-1:0]  perf_stall,  perf_bubble,  perf_flush,  perf_valid;
    logic [CNT_W-1:0]  perf_stall2, perf_bubble2, perf_flush2, perf_valid2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .STAGE(2), .STALL_W(6), .NOP_VALUE(NOP),
                     .AGE_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_bubble(out_bubble),
        .out_hold_age(out_hold_age), .perf_clr(perf_clr),
        .perf_stall(perf_stall), .perf_bubble(perf_bubble),
        .perf_flush(perf_flush), .perf_valid(perf_valid)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .STAGE(2), .STALL_W(6), .NOP_VALUE(NOP),
                     .AGE_W(2), .CNT_W(CNT_W)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data2), .out_valid(out_valid2), .out_bubble(out_bubble2),
        .out_hold_age(out_hold_age2), .perf_clr(perf_clr),
        .perf_stall(perf_stall2), .perf_bubble(perf_bubble2),
        .perf_flush(perf_flush2), .perf_valid(perf_valid2)
    );

    function automatic logic [CNT_W-1:0] pexp(input int n);
        return PERF ? CNT_W'(n) : '0;
    endfunction

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; stall = 6'b000000; perf_clr = 1'b0;
        in_data = 16'hFFFF; in_valid = 1'b1;
        tick();
        tick();
        total++; if (out_data !== NOP) $display("[TB] FAIL reset_data got %h want %h", out_data, NOP); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", out_valid); else passed++;
        total++; if (out_bubble !== 1'b0) $display("[TB] FAIL reset_bubble got %b want 0", out_bubble); else passed++;
        total++; if (out_hold_age !== 8'd0) $display("[TB] FAIL reset_age got %0d want 0", out_hold_age); else passed++;
        total++; if ({perf_stall, perf_bubble, perf_flush, perf_valid} !== '0)
            $display("[TB] FAIL reset_perf got %h/%h/%h/%h want all 0", perf_stall, perf_bubble, perf_flush, perf_valid); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_advance();
        stall = 6'b000000; in_data = 16'h1234; in_valid = 1'b1;
        tick();
        total++; if (out_data !== 16'h1234) $display("[TB] FAIL adv_data got %h want 1234", out_data); else passed++;
        total++; if (out_valid !== 1'b1) $display("[TB] FAIL adv_valid got %b want 1", out_valid); else passed++;
        total++; if (perf_valid !== pexp(1)) $display("[TB] FAIL adv_perf_valid got %0d want %0d", perf_valid, pexp(1)); else passed++;
        // An invalid slot keeps its payload; it is not replaced by the nop.
        in_data = 16'h5678; in_valid = 1'b0;
        tick();
        total++; if (out_data !== 16'h5678) $display("[TB] FAIL adv_inv_data got %h want 5678", out_data); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL adv_inv_valid got %b want 0", out_valid); else passed++;
        total++; if (perf_valid !== pexp(1)) $display("[TB] FAIL adv_inv_perf got %0d want %0d", perf_valid, pexp(1)); else passed++;
    endtask

    task automatic test_hold();
        stall = 6'b000000; in_data = 16'hABCD; in_valid = 1'b1;
        tick();
        stall = 6'b001111; in_data = 16'h9999; in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (out_data !== 16'hABCD || out_valid !== 1'b1)
                $display("[TB] FAIL hold_data_%0d got %h/%b want abcd/1", i, out_data, out_valid); else passed++;
            total++; if (out_hold_age !== 8'(i)) $display("[TB] FAIL hold_age_%0d got %0d want %0d", i, out_hold_age, i); else passed++;
        end
        total++; if (perf_stall !== pexp(4)) $display("[TB] FAIL hold_perf_stall got %0d want %0d", perf_stall, pexp(4)); else passed++;
    endtask

    task automatic test_bubble();
        stall = 6'b000111; in_data = 16'h2222; in_valid = 1'b1;
        tick();
        total++; if (out_data !== NOP || out_valid !== 1'b0 || out_bubble !== 1'b1)
            $display("[TB] FAIL bubble got %h/%b/%b want %h/0/1", out_data, out_valid, out_bubble, NOP); else passed++;
        total++; if (out_hold_age !== 8'd0) $display("[TB] FAIL bubble_age got %0d want 0", out_hold_age); else passed++;
        total++; if (perf_bubble !== pexp(1)) $display("[TB] FAIL bubble_perf got %0d want %0d", perf_bubble, pexp(1)); else passed++;
        stall = 6'b001111;
        for (int i = 1; i <= 2; i++) begin
            tick();
            total++; if (out_bubble !== 1'b1 || out_data !== NOP || out_hold_age !== 8'(i))
                $display("[TB] FAIL bubble_hold_%0d got %b/%h/%0d want 1/%h/%0d", i, out_bubble, out_data, out_hold_age, NOP, i); else passed++;
        end
        total++; if (perf_stall !== pexp(6)) $display("[TB] FAIL bubble_perf_stall got %0d want %0d", perf_stall, pexp(6)); else passed++;
    endtask

    task automatic test_down_only();
        // !up & down acts as ADVANCE.
        stall = 6'b001000; in_data = 16'h4321; in_valid = 1'b1;
        tick();
        total++; if (out_data !== 16'h4321 || out_valid !== 1'b1 || out_bubble !== 1'b0)
            $display("[TB] FAIL down_only got %h/%b/%b want 4321/1/0", out_data, out_valid, out_bubble); else passed++;
        total++; if (perf_valid !== pexp(3)) $display("[TB] FAIL down_only_perf got %0d want %0d", perf_valid, pexp(3)); else passed++;
    endtask

    task automatic test_flush();
        stall = 6'b000000; in_data = 16'h0055; in_valid = 1'b1;
        tick();
        stall = 6'b111111;
        tick();
        total++; if (out_data !== 16'h0055 || out_hold_age !== 8'd1)
            $display("[TB] FAIL flush_pre got %h/%0d want 0055/1", out_data, out_hold_age); else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (out_data !== NOP || out_valid !== 1'b0 || out_bubble !== 1'b0 || out_hold_age !== 8'd0)
            $display("[TB] FAIL flush got %h/%b/%b/%0d want %h/0/0/0", out_data, out_valid, out_bubble, out_hold_age, NOP); else passed++;
        total++; if (perf_flush !== pexp(1)) $display("[TB] FAIL flush_perf got %0d want %0d", perf_flush, pexp(1)); else passed++;
        total++; if (perf_stall !== pexp(7)) $display("[TB] FAIL flush_perf_stall got %0d want %0d", perf_stall, pexp(7)); else passed++;
    endtask

    task automatic test_age_sat();
        stall = 6'b000000; in_data = 16'h0077; in_valid = 1'b1;
        tick();
        stall = 6'b001111;
        for (int i = 1; i <= 6; i++) begin
            tick();
            total++; if (out_hold_age2 !== 2'((i > 3) ? 3 : i))
                $display("[TB] FAIL age_sat_%0d got %0d want %0d", i, out_hold_age2, (i > 3) ? 3 : i); else passed++;
        end
        total++; if (out_hold_age !== 8'd6) $display("[TB] FAIL age_wide got %0d want 6", out_hold_age); else passed++;
        total++; if (perf_stall !== pexp(13)) $display("[TB] FAIL age_perf_stall got %0d want %0d", perf_stall, pexp(13)); else passed++;
        // Clear during HOLD: the clear wins over that cycle's increment.
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        total++; if ({perf_stall, perf_bubble, perf_flush, perf_valid} !== '0)
            $display("[TB] FAIL perf_clr got %h/%h/%h/%h want all 0", perf_stall, perf_bubble, perf_flush, perf_valid); else passed++;
        total++; if (out_hold_age2 !== 2'd3 || out_data2 !== 16'h0077)
            $display("[TB] FAIL perf_clr_hold got %0d/%h want 3/0077", out_hold_age2, out_data2); else passed++;
        tick();
        total++; if (perf_stall !== pexp(1)) $display("[TB] FAIL perf_after_clr got %0d want %0d", perf_stall, pexp(1)); else passed++;
    endtask

    initial begin
        test_reset();
        test_advance();
        test_hold();
        test_bubble();
        test_down_only();
        test_flush();
        test_age_sat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
